spi_master_arbiter: RTL and testbench

//  - Shares one spi_master between NUM_REQ independent requesters, using round-robin arbitration.
//  - Each granted request becomes exactly one single-word spi_master transaction (burst_enable tied 0).
//  - Drives the enable/busy handshake with spi_master and returns read_word to the winning requester.
//  - Sits between the system-side clients and spi_master, on the same clock domain.

---
 rtl/spi_master_arbiter_if.sv | 44 ++++
 rtl/spi_master_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and spi_master.
// The master modport is the arbiter's view. The slave modport is the view
// of whatever sits on the other side: clients and the spi_master core.
interface spi_master_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    i_req_rw;
  logic [NUM_REQ*15-1:0] i_req_addr;
  logic [NUM_REQ*16-1:0] i_req_data;
  logic [NUM_REQ*16-1:0] i_req_divider;
  logic [NUM_REQ*2-1:0]  i_req_mode;
  logic [NUM_REQ-1:0]    i_req_lock;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ-1:0]    o_rsp_valid;
  logic                  o_rsp_err;
  logic [15:0]           o_rsp_data;
  logic                  o_spi_enable;
  logic                  o_spi_rw;
  logic [14:0]           o_spi_addr;
  logic [15:0]           o_spi_data;
  logic [15:0]           o_spi_divider;
  logic                  o_spi_cpol;
  logic                  o_spi_cpha;
  logic                  o_spi_burst_enable;
  logic                  i_spi_busy;
  logic [15:0]           i_spi_read_word;

  modport master (
    input  i_req_valid, i_req_rw, i_req_addr, i_req_data, i_req_divider,
    input  i_req_mode, i_req_lock, i_spi_busy, i_spi_read_word,
    output o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data,
    output o_spi_enable, o_spi_rw, o_spi_addr, o_spi_data, o_spi_divider,
    output o_spi_cpol, o_spi_cpha, o_spi_burst_enable
  );

  modport slave (
    output i_req_valid, i_req_rw, i_req_addr, i_req_data, i_req_divider,
    output i_req_mode, i_req_lock, i_spi_busy, i_spi_read_word,
    input  o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data,
    input  o_spi_enable, o_spi_rw, o_spi_addr, o_spi_data, o_spi_divider,
    input  o_spi_cpol, o_spi_cpha, o_spi_burst_enable
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ requesters.
// Each grant becomes one single-word transaction; the result is returned to
// the winner as a one-hot completion pulse, flagged as an error when
// spi_master never raised busy within LAUNCH_TIMEOUT cycles.
// Optional feature: define SPI_ARB_LOCK_EN to let the previous winner keep
// the bus while it holds i_req_lock together with i_req_valid.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int LAUNCH_TIMEOUT = 255
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  spi_master_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t state_q, state_d;
  // last_q holds the previous winner; it resets to NUM_REQ-1 so that the
  // scan from last_q+1 starts at requester 0 after reset.
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               en_q, en_d;
  logic               rw_q, rw_d;
  logic [14:0]        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic [15:0]        div_q, div_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          sel_rw;
  logic [14:0]   sel_addr;
  logic [15:0]   sel_data;
  logic [15:0]   sel_div;
  logic [1:0]    sel_mode;

`ifdef SPI_ARB_LOCK_EN
  // prev_q says last_q names a real winner rather than the reset value.
  logic prev_q, prev_d;
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_req_lock;
`endif

  // Pick the first valid requester after the previous winner (lock first).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && bus.i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef SPI_ARB_LOCK_EN
    if (prev_q && bus.i_req_valid[last_q] && bus.i_req_lock[last_q]) begin
      win_found = 1'b1;
      win_idx   = last_q;
    end
`endif
  end

  // Route the winner's transaction fields.
  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_div  = '0;
    sel_mode = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IW'(k)) begin
        sel_rw   = bus.i_req_rw[k];
        sel_addr = bus.i_req_addr[k*15 +: 15];
        sel_data = bus.i_req_data[k*16 +: 16];
        sel_div  = bus.i_req_divider[k*16 +: 16];
        sel_mode = bus.i_req_mode[k*2 +: 2];
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    en_d        = en_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    div_d       = div_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
`ifdef SPI_ARB_LOCK_EN
    prev_d      = prev_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          rw_d             = sel_rw;
          addr_d           = sel_addr;
          data_d           = sel_data;
          div_d            = sel_div;
          cpol_d           = sel_mode[1];
          cpha_d           = sel_mode[0];
          ready_d[win_idx] = 1'b1;
          last_d           = win_idx;
          en_d             = 1'b1;
          cnt_d            = '0;
          state_d          = LAUNCH;
`ifdef SPI_ARB_LOCK_EN
          prev_d           = 1'b1;
`endif
        end
      end
      LAUNCH: begin
        if (bus.i_spi_busy) begin
          en_d    = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(LAUNCH_TIMEOUT)) begin
          // spi_master never answered: abort and report to the winner.
          en_d                = 1'b0;
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = 1'b1;
          rsp_data_d          = '0;
          state_d             = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.i_spi_busy) begin
          rsp_valid_d[last_q] = 1'b1;
          rsp_data_d          = bus.i_spi_read_word;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, arbitration pointer and launch counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
`ifdef SPI_ARB_LOCK_EN
      prev_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef SPI_ARB_LOCK_EN
      prev_q  <= prev_d;
`endif
    end
  end

  // Registered outputs toward the clients and spi_master.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      div_q       <= div_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
    end
  end

  assign bus.o_req_ready        = ready_q;
  assign bus.o_rsp_valid        = rsp_valid_q;
  assign bus.o_rsp_err          = rsp_err_q;
  assign bus.o_rsp_data         = rsp_data_q;
  assign bus.o_spi_enable       = en_q;
  assign bus.o_spi_rw           = rw_q;
  assign bus.o_spi_addr         = addr_q;
  assign bus.o_spi_data         = data_q;
  assign bus.o_spi_divider      = div_q;
  assign bus.o_spi_cpol         = cpol_q;
  assign bus.o_spi_cpha         = cpha_q;
  assign bus.o_spi_burst_enable = 1'b0;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Testbench for spi_master_arbiter: random clients and a random spi_master
// responder, checked every cycle against a transaction-level model, plus
// directed checks of grant order, launch timeout and reset behaviour.
module tb_spi_master_arbiter;
  localparam int NR = 4;
  localparam int LT = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NUM_REQ(NR)) bus ();
  spi_master_arbiter #(.NUM_REQ(NR), .LAUNCH_TIMEOUT(LT)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Client-side stimulus, one entry per requester.
  logic [NR-1:0] valid_v, rw_v, lock_v;
  logic [14:0]   addr_a [NR];
  logic [15:0]   data_a [NR];
  logic [15:0]   div_a  [NR];
  logic [1:0]    mode_a [NR];
  logic          busy;
  logic [15:0]   rword;

  assign bus.i_req_valid     = valid_v;
  assign bus.i_req_rw        = rw_v;
  assign bus.i_req_lock      = lock_v;
  assign bus.i_spi_busy      = busy;
  assign bus.i_spi_read_word = rword;

  // Pack per-requester fields onto the bus.
  always_comb begin
    bus.i_req_addr    = '0;
    bus.i_req_data    = '0;
    bus.i_req_divider = '0;
    bus.i_req_mode    = '0;
    for (int k = 0; k < NR; k++) begin
      bus.i_req_addr[k*15 +: 15]    = addr_a[k];
      bus.i_req_data[k*16 +: 16]    = data_a[k];
      bus.i_req_divider[k*16 +: 16] = div_a[k];
      bus.i_req_mode[k*2 +: 2]      = mode_a[k];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: the bus is free, waiting for spi_master to start, or
  // spi_master is running. Arbitration is a rotation starting after the
  // last winner (none after reset, so requester 0 leads).
  int m_phase, m_last, m_w, m_age, m_win;
  logic [NR-1:0] e_ready, e_rvalid;
  logic          e_err, e_en, e_rw, e_cpol, e_cpha;
  logic [14:0]   e_addr;
  logic [15:0]   e_rdata, e_data, e_div;

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k + NR) % NR]) return (last + k + NR) % NR;
    return 0;
  endfunction

  always_comb begin
    m_win = rr_pick(valid_v, m_last);
`ifdef SPI_ARB_LOCK_EN
    if (m_last >= 0 && valid_v[m_last] && lock_v[m_last]) m_win = m_last;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_last <= -1; m_w <= 0; m_age <= 0;
      e_ready <= '0; e_rvalid <= '0; e_err <= 1'b0; e_rdata <= '0;
      e_en <= 1'b0; e_rw <= 1'b0; e_addr <= '0; e_data <= '0; e_div <= '0;
      e_cpol <= 1'b0; e_cpha <= 1'b0;
    end else begin
      e_ready  <= '0;
      e_rvalid <= '0;
      e_err    <= 1'b0;
      if (m_phase == 0) begin
        if (|valid_v) begin
          e_ready <= NR'(1 << m_win);
          m_w     <= m_win;
          m_last  <= m_win;
          e_rw    <= rw_v[m_win];
          e_addr  <= addr_a[m_win];
          e_data  <= data_a[m_win];
          e_div   <= div_a[m_win];
          e_cpol  <= mode_a[m_win][1];
          e_cpha  <= mode_a[m_win][0];
          e_en    <= 1'b1;
          m_age   <= 1;
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        if (busy) begin
          e_en    <= 1'b0;
          m_phase <= 2;
        end else if (m_age == LT + 1) begin
          e_en     <= 1'b0;
          e_rvalid <= NR'(1 << m_w);
          e_err    <= 1'b1;
          e_rdata  <= '0;
          m_phase  <= 0;
        end else begin
          m_age <= m_age + 1;
        end
      end else begin
        if (!busy) begin
          e_rvalid <= NR'(1 << m_w);
          e_rdata  <= rword;
          m_phase  <= 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_on = 1'b0;
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("req_ready", 64'(bus.o_req_ready), 64'(e_ready));
      chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(e_rvalid));
      chk("rsp_err",   64'(bus.o_rsp_err),   64'(e_err));
      chk("rsp_data",  64'(bus.o_rsp_data),  64'(e_rdata));
      chk("spi_enable", 64'(bus.o_spi_enable), 64'(e_en));
      chk("spi_fields",
          64'({bus.o_spi_rw, bus.o_spi_addr, bus.o_spi_data, bus.o_spi_divider, bus.o_spi_cpol, bus.o_spi_cpha}),
          64'({e_rw, e_addr, e_data, e_div, e_cpol, e_cpha}));
      chk("burst_enable", 64'(bus.o_spi_burst_enable), 64'(0));
    end
  end

  // ---------------- stimulus ----------------
  int glog[$];
  int cyc = 0, rdy_cyc = 0, rsp_cnt = 0;
  logic [NR-1:0] l_rv;
  logic          l_err;
  logic [15:0]   l_data;
  int sv_state = 0, sv_cnt = 0;

  task automatic new_fields(input int k);
    rw_v[k]   = 1'($urandom);
    addr_a[k] = 15'($urandom);
    data_a[k] = 16'($urandom);
    div_a[k]  = 16'($urandom_range(1, 8));
    mode_a[k] = 2'($urandom);
  endtask

  // md: 0 random, 1 all requesters keep asking, 2 one-shot with a silent
  // spi_master, 3 one-shot with a responsive spi_master.
  task automatic step(input int md);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NR; k++)
      if (bus.o_req_ready[k]) begin
        glog.push_back(k);
        rdy_cyc = cyc;
      end
    if (|bus.o_rsp_valid) begin
      rsp_cnt++;
      l_rv   = bus.o_rsp_valid;
      l_err  = bus.o_rsp_err;
      l_data = bus.o_rsp_data;
      if (bus.o_rsp_err) chk("timeout_latency", 64'(cyc - rdy_cyc), 64'(11));
    end
    for (int k = 0; k < NR; k++) begin
      if (valid_v[k] && bus.o_req_ready[k]) begin
        if (md == 1) new_fields(k);
        else if (md == 0 && $urandom_range(0, 1) == 1) new_fields(k);
        else valid_v[k] = 1'b0;
      end else if (valid_v[k]) begin
        if (md == 0 && $urandom_range(0, 19) == 0) valid_v[k] = 1'b0;
      end else begin
        new_fields(k);
        if (md == 0 && $urandom_range(0, 3) == 0) valid_v[k] = 1'b1;
      end
      lock_v[k] = ($urandom_range(0, 3) == 0);
    end
    rword = 16'($urandom);
    if (sv_state == 0 && bus.o_spi_enable) begin
      if (md == 2 || (md == 0 && $urandom_range(0, 7) == 0)) sv_state = 3;
      else begin
        sv_state = 1;
        sv_cnt   = $urandom_range(0, 3);
      end
    end
    if (sv_state == 1) begin
      if (sv_cnt == 0) begin
        busy     = 1'b1;
        sv_cnt   = $urandom_range(1, 5);
        sv_state = 2;
      end else sv_cnt--;
    end else if (sv_state == 2) begin
      if (sv_cnt == 0) begin
        busy     = 1'b0;
        sv_state = 0;
      end else sv_cnt--;
    end else if (sv_state == 3 && !bus.o_spi_enable) begin
      sv_state = 0;
    end
  endtask

  int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst_n = 1'b0;
    valid_v = '0; lock_v = '0; rw_v = '0; busy = 1'b0; rword = '0;
    for (int k = 0; k < NR; k++) new_fields(k);
    repeat (3) @(negedge clk);
    chk("reset_ready",  64'(bus.o_req_ready),  64'(0));
    chk("reset_rsp",    64'(bus.o_rsp_valid),  64'(0));
    chk("reset_enable", 64'(bus.o_spi_enable), 64'(0));
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // All four ask continuously: strict rotation from requester 0.
    valid_v = '1;
    for (int n = 0; n < 400 && glog.size() < 8; n++) step(1);
    chk("order_count", 64'(glog.size()), 64'(8));
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("grant_order", 64'(glog[i]), 64'(exp_order[i]));
    valid_v = '0;
    repeat (30) step(3);

    // Silent spi_master: requester 1 gets an error completion.
    glog.delete();
    rsp_cnt = 0;
    valid_v = 4'b0010;
    for (int n = 0; n < 100 && rsp_cnt == 0; n++) step(2);
    chk("timeout_seen",  64'(rsp_cnt), 64'(1));
    chk("timeout_valid", 64'(l_rv),    64'(4'b0010));
    chk("timeout_err",   64'(l_err),   64'(1));
    chk("timeout_data",  64'(l_data),  64'(0));
    repeat (5) step(3);

    // Random traffic.
    repeat (3000) step(0);
    valid_v = '0;
    repeat (30) step(3);

    // Reset while spi_master is busy.
    valid_v = 4'b0100;
    for (int n = 0; n < 60 && sv_state != 2; n++) step(3);
    chk("reached_busy", 64'(sv_state), 64'(2));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",  64'(bus.o_req_ready),  64'(0));
    chk("arst_rsp",    64'(bus.o_rsp_valid),  64'(0));
    chk("arst_data",   64'(bus.o_rsp_data),   64'(0));
    chk("arst_enable", 64'(bus.o_spi_enable), 64'(0));
    chk("arst_fields",
        64'({bus.o_spi_rw, bus.o_spi_addr, bus.o_spi_data, bus.o_spi_divider, bus.o_spi_cpol, bus.o_spi_cpha}),
        64'(0));
    valid_v  = '0;
    busy     = 1'b0;
    sv_state = 0;
    @(negedge clk);
    rst_n   = 1'b1;
    rsp_cnt = 0;
    repeat (10) step(3);
    chk("no_rsp_after_reset", 64'(rsp_cnt), 64'(0));
    glog.delete();
    valid_v = '1;
    for (int n = 0; n < 20 && glog.size() == 0; n++) step(3);
    chk("grant_after_reset_seen", 64'(glog.size()), 64'(1));
    if (glog.size() > 0) chk("grant_after_reset", 64'(glog[0]), 64'(0));
    valid_v = '0;
    repeat (30) step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
